// File: rtl/dsp_mul_sequencer.sv
// Multi-cycle RV32M multiply controller driving one external unsigned 16x16 multiplier.
// Optional MUL_EARLY_OUT_EN: plain MUL skips the HH pass since it only affects the high word.
module dsp_mul_sequencer #(
    parameter bit IDLE_ZERO_DSP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [1:0]  op_sel,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] result,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    input  logic [31:0] mul_p
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LL   = 3'd1,
        LH   = 3'd2,
        HL   = 3'd3,
        HH   = 3'd4,
        SIGN = 3'd5,
        DONE = 3'd6
    } state_t;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    // Two's-complement magnitude; 0x80000000 maps onto itself, which is the correct unsigned value.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_neg);
        return is_neg ? (~v + 32'd1) : v;
    endfunction

    state_t      state_r;
    state_t      next_state_s;
    logic        accept_s;
    logic        sign_a_s;
    logic        sign_b_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] a_mag_r;
    logic [31:0] b_mag_r;
    logic        neg_r;
    logic [1:0]  op_r;
    logic [63:0] acc_r;
    logic [15:0] mul_a_r;
    logic [15:0] mul_b_r;
    logic [15:0] mul_a_nxt_s;
    logic [15:0] mul_b_nxt_s;

    assign accept_s = (state_r == IDLE) && req_valid && !flush;
    assign sign_a_s = ((op_sel == OP_MULH) || (op_sel == OP_MULHSU)) && op_a[31];
    assign sign_b_s = (op_sel == OP_MULH) && op_b[31];
    assign a_mag_s  = magnitude(op_a, sign_a_s);
    assign b_mag_s  = magnitude(op_b, sign_b_s);
    assign mul_a    = mul_a_r;
    assign mul_b    = mul_b_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; flush overrides everything, including a pending acceptance
    always_comb begin
        next_state_s = state_r;
        if (flush) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    next_state_s = req_valid ? LL : IDLE;
                LL:      next_state_s = LH;
                LH:      next_state_s = HL;
`ifdef MUL_EARLY_OUT_EN
                HL:      next_state_s = (op_r == OP_MUL) ? SIGN : HH;
`else
                HL:      next_state_s = HH;
`endif
                HH:      next_state_s = SIGN;
                SIGN:    next_state_s = DONE;
                DONE:    next_state_s = resp_ready ? IDLE : DONE;
                default: next_state_s = IDLE;
            endcase
        end
    end

    // Output decode; multiplier operands are precomputed for the state being entered
    always_comb begin
        req_ready   = (state_r == IDLE) && !flush;
        resp_valid  = (state_r == DONE);
        result      = (op_r == OP_MUL) ? acc_r[31:0] : acc_r[63:32];
        mul_a_nxt_s = IDLE_ZERO_DSP ? 16'd0 : mul_a_r;
        mul_b_nxt_s = IDLE_ZERO_DSP ? 16'd0 : mul_b_r;
        case (next_state_s)
            LL: begin
                mul_a_nxt_s = a_mag_s[15:0];
                mul_b_nxt_s = b_mag_s[15:0];
            end
            LH: begin
                mul_a_nxt_s = a_mag_r[15:0];
                mul_b_nxt_s = b_mag_r[31:16];
            end
            HL: begin
                mul_a_nxt_s = a_mag_r[31:16];
                mul_b_nxt_s = b_mag_r[15:0];
            end
            HH: begin
                mul_a_nxt_s = a_mag_r[31:16];
                mul_b_nxt_s = b_mag_r[31:16];
            end
            default: begin
                mul_a_nxt_s = IDLE_ZERO_DSP ? 16'd0 : mul_a_r;
                mul_b_nxt_s = IDLE_ZERO_DSP ? 16'd0 : mul_b_r;
            end
        endcase
    end

    // Multiplier operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a_r <= 16'd0;
            mul_b_r <= 16'd0;
        end else begin
            mul_a_r <= mul_a_nxt_s;
            mul_b_r <= mul_b_nxt_s;
        end
    end

    // Operand magnitudes, sign and opcode captured only at acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_mag_r <= 32'd0;
            b_mag_r <= 32'd0;
            neg_r   <= 1'b0;
            op_r    <= 2'b00;
        end else if (accept_s) begin
            a_mag_r <= a_mag_s;
            b_mag_r <= b_mag_s;
            neg_r   <= sign_a_s ^ sign_b_s;
            op_r    <= op_sel;
        end else begin
            a_mag_r <= a_mag_r;
            b_mag_r <= b_mag_r;
            neg_r   <= neg_r;
            op_r    <= op_r;
        end
    end

    // Accumulator: partial products weighted by 2^0, 2^16, 2^16, 2^32, then sign fix-up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= 64'd0;
        end else if (accept_s) begin
            acc_r <= 64'd0;
        end else begin
            case (state_r)
                LL:      acc_r <= {32'd0, mul_p};
                LH:      acc_r <= acc_r + ({32'd0, mul_p} << 16);
                HL:      acc_r <= acc_r + ({32'd0, mul_p} << 16);
                HH:      acc_r <= acc_r + ({32'd0, mul_p} << 32);
                SIGN:    acc_r <= neg_r ? (~acc_r + 64'd1) : acc_r;
                default: acc_r <= acc_r;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_mul_sequencer.sv
// Self-checking bench for dsp_mul_sequencer with an arithmetic reference model of RV32M multiplies.
// Honours MUL_EARLY_OUT_EN when computing the expected latency.
module tb_dsp_mul_sequencer;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [1:0]  op_sel;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] result;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [31:0] mul_p;

    int n_checks = 0;
    int n_fail   = 0;

    dsp_mul_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_sel     (op_sel),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_p      (mul_p)
    );

    // External unsigned multiplier, combinational
    assign mul_p = {16'h0000, mul_a} * {16'h0000, mul_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // True 64-bit product of the operands as RV32M interprets them, then word select
    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [1:0] sel);
        logic [63:0] ae;
        logic [63:0] be;
        logic [63:0] p;
        ae = (sel == 2'b01 || sel == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        be = (sel == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ae * be;
        return (sel == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel,
                         input int hold, input string tag);
        logic [31:0] exp_r;
        int lat;
        int exp_lat;
        exp_r   = ref_result(a, b, sel);
        exp_lat = 5;
`ifdef MUL_EARLY_OUT_EN
        if (sel == 2'b00) exp_lat = 4;
`endif
        @(negedge clk);
        op_a = a; op_b = b; op_sel = sel; req_valid = 1'b1;
        #1;
        check({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        op_a = $urandom; op_b = $urandom; op_sel = 2'($urandom);
        wait_resp(lat);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, result, exp_r);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, " held result"}, result, exp_r);
            check({tag, " held resp_valid"}, {31'd0, resp_valid}, 32'd1);
            check({tag, " held req_ready"}, {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, " resp_valid drop"}, {31'd0, resp_valid}, 32'd0);
        check({tag, " req_ready back"}, {31'd0, req_ready}, 32'd1);
        check({tag, " idle mul_a"}, {16'd0, mul_a}, 32'd0);
        check({tag, " idle mul_b"}, {16'd0, mul_b}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rs;
        logic [31:0] corner [4];
        corner[0] = 32'h8000_0000; corner[1] = 32'h0000_0000;
        corner[2] = 32'hFFFF_FFFF; corner[3] = 32'h7FFF_FFFF;

        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        op_a = 32'd0; op_b = 32'd0; op_sel = 2'b00;
        #12;
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset mul_a", {16'd0, mul_a}, 32'd0);
        check("reset mul_b", {16'd0, mul_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(32'h0001_0003, 32'h0002_0005, 2'b00, 0, "mul small");
        check("mul small const", result, 32'h000B_000F);
        do_op(32'h0001_0003, 32'h0002_0005, 2'b11, 0, "mulhu small");
        do_op(32'hFFFF_FFFF, 32'h0000_0002, 2'b01, 0, "mulh -1x2");
        do_op(32'hFFFF_FFFF, 32'h0000_0002, 2'b11, 0, "mulhu -1x2");
        do_op(32'hFFFF_FFFF, 32'h0000_0002, 2'b10, 0, "mulhsu -1x2");
        do_op(32'h8000_0000, 32'h8000_0000, 2'b01, 0, "mulh min");
        do_op(32'h8000_0000, 32'h8000_0000, 2'b10, 0, "mulhsu min");
        do_op(32'h8000_0000, 32'h8000_0000, 2'b00, 0, "mul min");
        do_op(32'h0000_0000, 32'hFFFF_FFF0, 2'b01, 0, "mulh zero");

        do_op(32'h1234_5678, 32'h9ABC_DEF0, 2'b01, 3, "backpressure");

        // Flush during HL with a new request held; the held request is taken after flush drops
        @(negedge clk);
        op_a = 32'h0BAD_F00D; op_b = 32'h1357_9BDF; op_sel = 2'b11; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("flush LL..LH resp_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b1; req_valid = 1'b1;
        op_a = 32'hFFFF_8001; op_b = 32'h0000_7FFF; op_sel = 2'b01;
        #1;
        check("flush req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1;
        check("post flush req_ready", {31'd0, req_ready}, 32'd1);
        check("post flush resp_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        op_a = $urandom; op_b = $urandom;
        wait_resp(lat);
        check("flush held latency", 32'(lat), 32'd5);
        check("flush held result", result, ref_result(32'hFFFF_8001, 32'h0000_7FFF, 2'b01));
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("flush held done", {31'd0, resp_valid}, 32'd0);

        // Asynchronous reset while in LH
        @(negedge clk);
        op_a = 32'h0003_0005; op_b = 32'h0007_0009; op_sel = 2'b11; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("LH mul_a", {16'd0, mul_a}, 32'h0000_0005);
        check("LH mul_b", {16'd0, mul_b}, 32'h0000_0007);
        #1;
        rst_n = 1'b0;
        #1;
        check("async rst req_ready", {31'd0, req_ready}, 32'd1);
        check("async rst resp_valid", {31'd0, resp_valid}, 32'd0);
        check("async rst result", result, 32'd0);
        check("async rst mul_a", {16'd0, mul_a}, 32'd0);
        check("async rst mul_b", {16'd0, mul_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'hFEDC_BA98, 32'h7654_3210, 2'b10, 0, "after reset");

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 2'($urandom);
            if ((i % 5) == 0) ra = corner[$urandom_range(0, 3)];
            if ((i % 7) == 0) rb = corner[$urandom_range(0, 3)];
            do_op(ra, rb, rs, i % 2, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
